alu_operand_loader: RTL and testbench
=====================================

# alu_operand_loader

Input front end for the 3-bit ALU board build. It turns a single push-button and one 3-bit switch field into the registered operand set A, B, S. The block synchronizes and debounces the key, then steps an FSM that latches the switch value into A, then B, then S on successive presses. The loaded operands drive the ALU; the `stage` LEDs show the user which operand is loaded next.

## Interface
Parameters:
- `WIDTH`, 3: width of the switch field and of each operand register.
- `DEB_CYCLES`, 500000: number of consecutive stable clock cycles required to accept a key level change. This is 10 ms at 50 MHz. Must be ≥ 2.

Ports:
- `clk` input 1: system clock; the block's only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `sw_data` input WIDTH: switch field sampled on each accepted press; treated as quasi-static.
- `btn_n` input 1: load key, active-low, raw/bouncy.
- `clr_n` input 1: clear key, active-low, raw.
- `A` output WIDTH: operand A register.
- `B` output WIDTH: operand B register.
- `S` output WIDTH: operation-select register.
- `valid` output 1: high while A, B and S are all loaded (state RDY).
- `stage` output 2: current state encoding, drives LEDs.
- `press` output 1: one-cycle pulse for each accepted load press.

## Operation
- Reset values:
  - `A`, `B`, `S` = 0; `valid` = 0; `stage` = 2'd0 (LD_A); `press` = 0.
  - Both synchronizer chains reset to 1 (released).
  - Debounced level resets to 1; debounce counter resets to 0.
- Synchronizers: two-flop chains on `btn_n` and on `clr_n`. They are always present.
- Debounce (`btn_n` path only):
  - The counter increments each cycle the synchronized level differs from the debounced level, and clears to 0 on any cycle they are equal.
  - When the counter reaches DEB_CYCLES-1 while the levels still differ, the debounced level takes the synchronized level and the counter clears.
  - Counter width is $clog2(DEB_CYCLES); it never wraps.
- `press` is registered. It is high for exactly one cycle after a 1→0 transition of the debounced level.
- Release (0→1) generates nothing, so a held key yields one press only.
- FSM states and `stage` encoding:
  - LD_A = 0: on `press`, A ← `sw_data`; go to LD_B.
  - LD_B = 1: on `press`, B ← `sw_data`; go to LD_S.
  - LD_S = 2: on `press`, S ← `sw_data`; go to RDY.
  - RDY = 3: `valid` = 1. On `press`, A ← `sw_data` and go to LD_B; this new-entry press reloads A and `valid` drops the cycle after.
- `valid` is a registered flag, equal to (state == RDY).
- Clear: the synchronized `clr_n` low, on the same edge, does all of the following:
  - Forces the state to LD_A.
  - Zeroes A, B and S.
  - Drops `valid`.
- Clear is level-sensitive and not debounced; bounce only re-clears.
- Simultaneous `press` and clear: clear wins and no register is loaded.
- Asserting `rst_n` mid-sequence returns every output to its reset value immediately, without waiting for a clock.
- `sw_data` is not synchronized. It is captured only on the `press` edge, which comes at least DEB_CYCLES after the user touches the key.

## Timing
Edge 0 is the first edge that samples `btn_n` = 0, with the key held stable afterwards.
- With debounce: the debounced level falls at edge DEB_CYCLES+1. `press` is high after edge DEB_CYCLES+2. The operand register and `stage` update at edge DEB_CYCLES+3.
- Without debounce: `press` is high after edge 2; the register and state update at edge 3.
- Clear: the synchronized `clr_n` acts at edge 1 after sampling. Outputs are cleared after edge 2.
- A glitch on `btn_n` shorter than DEB_CYCLES cycles produces no `press`.
- Minimum spacing between accepted presses is 2·DEB_CYCLES cycles, because a release must also be accepted.

## Configuration
- `ALU_LOADER_DEBOUNCE_EN` defined: the debounce counter is present, as in Operation/Timing.
- Not defined: the debounced level is the second synchronizer flop. There is no counter, `DEB_CYCLES` is ignored, and every synchronized falling edge is a press.

## Test plan
All scenarios use DEB_CYCLES = 4 with the macro defined, unless noted.
- Reset then idle: check `A`=`B`=`S`=0, `valid`=0, `stage`=0 and `press` never asserts for 100 cycles.
- Load sequence: press with `sw_data`=3'b101, then 3'b011, then 3'b010 (key held ≥6 cycles, released ≥6 cycles). Expect A=5, B=3, S=2, `stage`=3, `valid`=1, and exactly 3 `press` pulses, each followed by its register update one cycle later.
- Bounce rejection: toggle `btn_n` low/high every 2 cycles for 20 cycles, then hold low 10 cycles. Expect exactly one `press`, A loaded once.
- Clear priority: in state LD_S, assert `clr_n` low in the same cycle `press` fires. Expect S unchanged (0), A=B=0, `stage`=0, `valid`=0.
- Wrap from RDY: from A=5, B=3, S=2, `valid`=1, press with `sw_data`=3'b111. Expect A=7, `stage`=1, `valid`=0, and B and S retained.
- Async reset mid-debounce: assert `rst_n` low while the counter = 2. Expect all outputs at reset values immediately and no `press` after release. Repeat with the macro undefined: `press` comes 2 edges after sampling and A is loaded at edge 3.

Source files
------------

// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_loader
// Purpose  : Input front end for the 3-bit ALU board build. A single raw,
//            active-low push-button and one switch field are turned into the
//            registered operand set A, B, S. The key is synchronized and
//            (optionally) debounced; each accepted press latches the switch
//            value into A, then B, then S. A fourth press after all three are
//            loaded starts a new entry by reloading A.
//
// Config   : `ALU_LOADER_DEBOUNCE_EN
//              defined   - debounce counter present; a key level change is
//                          accepted after DEB_CYCLES consecutive stable cycles.
//              undefined - the debounced level is the second synchronizer
//                          flop; DEB_CYCLES is ignored.
//
// Params   : WIDTH      - width of the switch field and of each operand.
//            DEB_CYCLES - stable cycles needed to accept a key change (>= 2).
//
// Ports    : clk      in   system clock (only clock)
//            rst_n    in   asynchronous active-low reset
//            sw_data  in   switch field, captured on each accepted press
//            btn_n    in   load key, active-low, raw/bouncy
//            clr_n    in   clear key, active-low, raw, level-sensitive
//            A        out  operand A register
//            B        out  operand B register
//            S        out  operation-select register
//            valid    out  high while A, B and S are all loaded (RDY)
//            stage    out  current state encoding (LED drive)
//            press    out  one-cycle pulse per accepted load press
//
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_loader #(
    parameter int WIDTH      = 3,
    parameter int DEB_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             btn_n,
    input  logic             clr_n,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             valid,
    output logic [1:0]       stage,
    output logic             press
);

    // ------------------------------------------------------------------------
    // State encoding; the raw state value is what the stage LEDs display.
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_LD_A = 2'd0;
    localparam logic [1:0] c_LD_B = 2'd1;
    localparam logic [1:0] c_LD_S = 2'd2;
    localparam logic [1:0] c_RDY  = 2'd3;

    // ------------------------------------------------------------------------
    // Two-flop synchronizers. Both reset to the released (high) level so a
    // reset never looks like a key press.
    // ------------------------------------------------------------------------
    logic [1:0] r_btn_sync;
    logic [1:0] r_clr_sync;
    logic       w_btn_s;
    logic       w_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_sync <= 2'b11;
            r_clr_sync <= 2'b11;
        end else begin
            r_btn_sync <= {r_btn_sync[0], btn_n};
            r_clr_sync <= {r_clr_sync[0], clr_n};
        end
    end

    assign w_btn_s = r_btn_sync[1];
    assign w_clr   = ~r_clr_sync[1];

    // ------------------------------------------------------------------------
    // Debounced key level (w_deb, active-low like the key itself).
    // ------------------------------------------------------------------------
    logic w_deb;

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int                 c_CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEB_CYCLES - 1);

    logic [c_CNT_W-1:0] r_deb_cnt;
    logic               r_deb;

    // The counter measures how long the synchronized level has disagreed with
    // the accepted level. Any agreeing cycle restarts the measurement, so a
    // bounce shorter than DEB_CYCLES is discarded. The counter is cleared at
    // its terminal value, so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt <= '0;
            r_deb     <= 1'b1;
        end else if (w_btn_s == r_deb) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_CNT_MAX) begin
            r_deb     <= w_btn_s;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign w_deb = r_deb;
`else
    assign w_deb = w_btn_s;
`endif

    // ------------------------------------------------------------------------
    // Press detection: a registered pulse on each falling edge of the
    // debounced level. Releases produce nothing, so a held key is one press.
    // ------------------------------------------------------------------------
    logic r_deb_d;
    logic r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_d <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_deb_d <= w_deb;
            r_press <= r_deb_d & ~w_deb;
        end
    end

    // ------------------------------------------------------------------------
    // Operand-entry FSM, next-state and register-load logic.
    // Clear has priority over a coincident press: nothing is loaded.
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_s_nxt;
    logic             r_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_s_nxt     = r_s;

        if (w_clr) begin
            w_state_nxt = c_LD_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_s_nxt     = '0;
        end else if (r_press) begin
            case (r_state)
                c_LD_A: begin
                    w_a_nxt     = sw_data;
                    w_state_nxt = c_LD_B;
                end
                c_LD_B: begin
                    w_b_nxt     = sw_data;
                    w_state_nxt = c_LD_S;
                end
                c_LD_S: begin
                    w_s_nxt     = sw_data;
                    w_state_nxt = c_RDY;
                end
                default: begin
                    // A press in RDY starts a new entry: reload A, keep B/S.
                    w_a_nxt     = sw_data;
                    w_state_nxt = c_LD_B;
                end
            endcase
        end
    end

    // valid is registered from the next state so it always equals
    // (state == RDY) without an extra cycle of lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_LD_A;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_s     <= w_s_nxt;
            r_valid <= (w_state_nxt == c_RDY);
        end
    end

    assign A     = r_a;
    assign B     = r_b;
    assign S     = r_s;
    assign valid = r_valid;
    assign stage = r_state;
    assign press = r_press;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_loader
// Purpose  : Self-checking bench for alu_operand_loader (WIDTH=3,
//            DEB_CYCLES=4). Directed scenarios plus a randomized phase, all
//            checked cycle by cycle against a behavioural model that follows
//            the key/clear/operand-entry rules, plus directed constant checks
//            at the scenario boundaries. Adapts its expectations to whether
//            ALU_LOADER_DEBOUNCE_EN is defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

    localparam int DEB = 4;
`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam bit c_DEB_EN = 1'b1;
`else
    localparam bit c_DEB_EN = 1'b0;
`endif
    // Edge after which press is high, counting from the first edge that
    // samples the key low.
    localparam int c_PRESS_EDGE = c_DEB_EN ? DEB + 2 : 2;
    // Presses produced by the bounce pattern (5 short lows + 1 long low).
    localparam int c_BOUNCE_PRESSES = c_DEB_EN ? 1 : 6;

    logic       clk;
    logic       rst_n;
    logic [2:0] sw_data;
    logic       btn_n;
    logic       clr_n;
    logic [2:0] A;
    logic [2:0] B;
    logic [2:0] S;
    logic       valid;
    logic [1:0] stage;
    logic       press;

    int n_tests;
    int n_fail;
    int press_cnt;
    int base;

    alu_operand_loader #(.WIDTH(3), .DEB_CYCLES(DEB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_data (sw_data),
        .btn_n   (btn_n),
        .clr_n   (clr_n),
        .A       (A),
        .B       (B),
        .S       (S),
        .valid   (valid),
        .stage   (stage),
        .press   (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_a, m_b, m_s, m_stage, m_run;
    bit m_press, m_deb, m_deb_d;
    bit m_rb [2];   // [0] raw key one edge ago, [1] two edges ago
    bit m_rc [2];

    task automatic model_reset();
        m_a = 0; m_b = 0; m_s = 0; m_stage = 0; m_run = 0;
        m_press = 0; m_deb = 1; m_deb_d = 1;
        m_rb[0] = 1; m_rb[1] = 1; m_rc[0] = 1; m_rc[1] = 1;
    endtask

    // One clock edge: b/c/sw are the values present at that edge.
    task automatic model_edge(input bit b, input bit c, input int sw);
        bit s_btn, s_clr, nd, np;
        s_btn = m_rb[1];
        s_clr = m_rc[1];
        if (!s_clr) begin
            m_a = 0; m_b = 0; m_s = 0; m_stage = 0;
        end else if (m_press) begin
            case (m_stage)
                0: begin m_a = sw; m_stage = 1; end
                1: begin m_b = sw; m_stage = 2; end
                2: begin m_s = sw; m_stage = 3; end
                default: begin m_a = sw; m_stage = 1; end
            endcase
        end
        np = m_deb_d & ~m_deb;
        if (c_DEB_EN) begin
            nd = m_deb;
            if (s_btn != m_deb) begin
                m_run++;
                if (m_run == DEB) begin
                    nd = s_btn;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            nd = m_rb[0];
        end
        m_deb_d = m_deb;
        m_deb   = nd;
        m_press = np;
        m_rb[1] = m_rb[0]; m_rb[0] = b;
        m_rc[1] = m_rc[0]; m_rc[0] = c;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("press", 8'(press), 8'(m_press));
        chk("A",     8'(A),     8'(m_a));
        chk("B",     8'(B),     8'(m_b));
        chk("S",     8'(S),     8'(m_s));
        chk("stage", 8'(stage), 8'(m_stage));
        chk("valid", 8'(valid), 8'(m_stage == 3));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_A"},     8'(A),     8'd0);
        chk({tag, "_B"},     8'(B),     8'd0);
        chk({tag, "_S"},     8'(S),     8'd0);
        chk({tag, "_valid"}, 8'(valid), 8'd0);
        chk({tag, "_stage"}, 8'(stage), 8'd0);
        chk({tag, "_press"}, 8'(press), 8'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(btn_n, clr_n, int'(sw_data));
        @(negedge clk);
        if (rst_n) check_model();
        if (press === 1'b1) press_cnt++;
    endtask

    task automatic press_key(input logic [2:0] sw, input int hold, input int rel);
        sw_data = sw;
        btn_n   = 1'b0;
        repeat (hold) tick();
        btn_n   = 1'b1;
        repeat (rel) tick();
    endtask

    task automatic do_clear();
        clr_n = 1'b0;
        repeat (4) tick();
        clr_n = 1'b1;
        repeat (4) tick();
    endtask

    logic       lat_press [0:c_PRESS_EDGE+1];
    logic [2:0] lat_a     [0:c_PRESS_EDGE+1];

    initial begin
        n_tests = 0; n_fail = 0; press_cnt = 0;
        rst_n = 1'b1; btn_n = 1'b1; clr_n = 1'b1; sw_data = 3'd0;
        model_reset();

        // Reset then idle
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (100) tick();
        chk("idle_press_cnt", 8'(press_cnt), 8'd0);
        check_reset_vals("idle");

        // Load sequence A=5, B=3, S=2
        base = press_cnt;
        press_key(3'b101, 6, 6);
        press_key(3'b011, 6, 6);
        press_key(3'b010, 6, 6);
        chk("load_presses", 8'(press_cnt - base), 8'd3);
        chk("load_A", 8'(A), 8'd5);
        chk("load_B", 8'(B), 8'd3);
        chk("load_S", 8'(S), 8'd2);
        chk("load_stage", 8'(stage), 8'd3);
        chk("load_valid", 8'(valid), 8'd1);

        // Wrap from RDY: new entry reloads A only
        press_key(3'b111, 6, 6);
        chk("wrap_A", 8'(A), 8'd7);
        chk("wrap_B", 8'(B), 8'd3);
        chk("wrap_S", 8'(S), 8'd2);
        chk("wrap_stage", 8'(stage), 8'd1);
        chk("wrap_valid", 8'(valid), 8'd0);

        // Clear priority: clear lands on the same edge the press is consumed
        press_key(3'b001, 6, 6);
        chk("pre_clr_stage", 8'(stage), 8'd2);
        base = press_cnt;
        sw_data = 3'b100;
        btn_n   = 1'b0;
        repeat (c_PRESS_EDGE - 1) tick();
        clr_n = 1'b0;
        repeat (4) tick();
        clr_n = 1'b1;
        repeat (4) tick();
        btn_n = 1'b1;
        repeat (8) tick();
        chk("clr_presses", 8'(press_cnt - base), 8'd1);
        chk("clr_A", 8'(A), 8'd0);
        chk("clr_B", 8'(B), 8'd0);
        chk("clr_S", 8'(S), 8'd0);
        chk("clr_stage", 8'(stage), 8'd0);
        chk("clr_valid", 8'(valid), 8'd0);

        // Bounce rejection
        base = press_cnt;
        sw_data = 3'b010;
        repeat (5) begin
            btn_n = 1'b0; repeat (2) tick();
            btn_n = 1'b1; repeat (2) tick();
        end
        btn_n = 1'b0; repeat (10) tick();
        btn_n = 1'b1; repeat (8) tick();
        chk("bounce_presses", 8'(press_cnt - base), 8'(c_BOUNCE_PRESSES));
        chk("bounce_A", 8'(A), 8'd2);

        // Press and load latency from the first low sample
        do_clear();
        sw_data = 3'b110;
        btn_n   = 1'b0;
        for (int i = 0; i <= c_PRESS_EDGE + 1; i++) begin
            tick();
            lat_press[i] = press;
            lat_a[i]     = A;
        end
        chk("lat_press_early", 8'(lat_press[c_PRESS_EDGE-1]), 8'd0);
        chk("lat_press_edge",  8'(lat_press[c_PRESS_EDGE]),   8'd1);
        chk("lat_A_early",     8'(lat_a[c_PRESS_EDGE]),       8'd0);
        chk("lat_A_load",      8'(lat_a[c_PRESS_EDGE+1]),     8'd6);
        repeat (4) tick();
        btn_n = 1'b1;
        repeat (8) tick();

        // Async reset mid-debounce (counter = 2 after edge 3)
        do_clear();
        sw_data = 3'b011;
        btn_n   = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1 check_reset_vals("arst");
        model_reset();
        btn_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        base = press_cnt;
        repeat (20) tick();
        chk("arst_presses", 8'(press_cnt - base), 8'd0);

        // Randomized phase: presses, short glitches, clear pulses
        repeat (30) begin
            int kind;
            kind = int'($urandom_range(0, 7));
            if (kind <= 5) begin
                press_key(3'($urandom_range(0, 7)),
                          int'($urandom_range(6, 9)), int'($urandom_range(6, 9)));
            end else if (kind == 6) begin
                btn_n = 1'b0;
                repeat (int'($urandom_range(1, 3))) tick();
                btn_n = 1'b1;
                repeat (6) tick();
            end else begin
                clr_n = 1'b0;
                repeat (int'($urandom_range(1, 3))) tick();
                clr_n = 1'b1;
                repeat (3) tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
